// File: rtl/tapa_global_fsm_gen2.sv
// Global launch/supervise/complete controller for a set of child tasks.
// Latches arguments at launch, tracks sticky per-task completion, optional done delay and RUN timeout.
module tapa_global_fsm_gen2 #(
  parameter int unsigned NUM_TASKS  = 7,
  parameter int unsigned ARG_W      = 288,
  parameter int unsigned DONE_DELAY = 0,
  parameter int unsigned TMO_W      = 32
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst,
  input  logic                 ap_start,
  output logic                 ap_done,
  output logic                 ap_ready,
  output logic                 ap_idle,
  input  logic [ARG_W-1:0]     args_in,
  output logic [ARG_W-1:0]     args_out,
  input  logic [NUM_TASKS-1:0] task_mask,
  output logic [NUM_TASKS-1:0] task_start,
  input  logic [NUM_TASKS-1:0] task_done,
  output logic [NUM_TASKS-1:0] done_status,
  input  logic [TMO_W-1:0]     tmo_cycles,
  output logic                 tmo_err,
  output logic [31:0]          iter_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DELAY = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [7:0] CNT_INIT = (DONE_DELAY > 0) ? 8'(DONE_DELAY - 1) : 8'd0;

  logic [1:0]           state_q, state_d;
  logic [ARG_W-1:0]     args_q, args_d;
  logic [NUM_TASKS-1:0] mask_q, mask_d;
  logic [NUM_TASKS-1:0] task_start_q, task_start_d;
  logic [NUM_TASKS-1:0] done_status_q, done_status_d;
  logic                 tmo_err_q, tmo_err_d;
  logic [31:0]          iter_q, iter_d;
  logic [TMO_W-1:0]     timer_q, timer_d;
  logic [7:0]           cnt_q, cnt_d;

  logic all_done;
  logic tmo_hit;
  logic launch;

  // Same-cycle done bits count toward completion so a task finishing now does not cost a cycle.
  assign all_done = (((done_status_q | task_done) & mask_q) == mask_q);
  assign tmo_hit  = (tmo_cycles != '0) && (timer_q == (tmo_cycles - TMO_W'(1)));
  assign launch   = ap_start && ((state_q == S_IDLE) || (state_q == S_DONE));

  always_comb begin
    state_d       = state_q;
    args_d        = args_q;
    mask_d        = mask_q;
    task_start_d  = '0;
    done_status_d = done_status_q;
    tmo_err_d     = tmo_err_q;
    iter_d        = iter_q;
    timer_d       = timer_q;
    cnt_d         = cnt_q;

    case (state_q)
      S_RUN: begin
        timer_d       = timer_q + TMO_W'(1);
        done_status_d = done_status_q | (task_done & mask_q);
        if (all_done) begin
          if (DONE_DELAY == 0) begin
            state_d = S_DONE;
          end else begin
            cnt_d   = CNT_INIT;
            state_d = S_DELAY;
          end
        end else if (tmo_hit) begin
          tmo_err_d = 1'b1;
          state_d   = S_DONE;
        end
      end
      S_DELAY: begin
        if (cnt_q == 8'd0) state_d = S_DONE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      S_DONE: begin
        iter_d  = iter_q + 32'd1;
        state_d = S_IDLE;
      end
      default: ;
    endcase

    // A launch from DONE overrides the return to IDLE but keeps the iteration increment.
    if (launch) begin
      args_d        = args_in;
      mask_d        = task_mask;
      done_status_d = '0;
      tmo_err_d     = 1'b0;
      timer_d       = '0;
      task_start_d  = task_mask;
      state_d       = S_RUN;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q       <= S_IDLE;
      args_q        <= '0;
      mask_q        <= '0;
      task_start_q  <= '0;
      done_status_q <= '0;
      tmo_err_q     <= 1'b0;
      iter_q        <= '0;
      timer_q       <= '0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      args_q        <= args_d;
      mask_q        <= mask_d;
      task_start_q  <= task_start_d;
      done_status_q <= done_status_d;
      tmo_err_q     <= tmo_err_d;
      iter_q        <= iter_d;
      timer_q       <= timer_d;
      cnt_q         <= cnt_d;
    end
  end

  assign ap_idle     = (state_q == S_IDLE);
  assign ap_done     = (state_q == S_DONE);
  assign ap_ready    = ap_done;
  assign args_out    = args_q;
  assign task_start  = task_start_q;
  assign done_status = done_status_q;
  assign tmo_err     = tmo_err_q;
  assign iter_count  = iter_q;

endmodule

// File: tb/tb_tapa_global_fsm_gen2.sv
// Directed bench for tapa_global_fsm_gen2: instance a has DONE_DELAY=0, instance b has DONE_DELAY=3.
module tb_tapa_global_fsm_gen2;

  logic         ap_clk;
  logic         ap_rst;
  logic         ap_start;
  logic [287:0] args_in;
  logic [6:0]   task_mask;
  logic [6:0]   task_done;
  logic [31:0]  tmo_cycles;

  logic         a_done, a_ready, a_idle, a_tmo;
  logic [287:0] a_args;
  logic [6:0]   a_tstart, a_dstat;
  logic [31:0]  a_iter;
  logic         b_done, b_ready, b_idle, b_tmo;
  logic [287:0] b_args;
  logic [6:0]   b_tstart, b_dstat;
  logic [31:0]  b_iter;

  int nvec = 0;
  int nerr = 0;
  int exp_iter = 0;
  int sched [7] = '{3, 5, 8, 11, 14, 17, 20};

  tapa_global_fsm_gen2 #(.NUM_TASKS(7), .ARG_W(288), .DONE_DELAY(0), .TMO_W(32)) u_a (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start), .ap_done(a_done),
    .ap_ready(a_ready), .ap_idle(a_idle), .args_in(args_in), .args_out(a_args),
    .task_mask(task_mask), .task_start(a_tstart), .task_done(task_done),
    .done_status(a_dstat), .tmo_cycles(tmo_cycles), .tmo_err(a_tmo), .iter_count(a_iter)
  );

  tapa_global_fsm_gen2 #(.NUM_TASKS(7), .ARG_W(288), .DONE_DELAY(3), .TMO_W(32)) u_b (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start), .ap_done(b_done),
    .ap_ready(b_ready), .ap_idle(b_idle), .args_in(args_in), .args_out(b_args),
    .task_mask(task_mask), .task_start(b_tstart), .task_done(task_done),
    .done_status(b_dstat), .tmo_cycles(tmo_cycles), .tmo_err(b_tmo), .iter_count(b_iter)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  function automatic logic [287:0] pat(input int s);
    logic [287:0] r;
    for (int i = 0; i < 9; i++) r[i*32 +: 32] = 32'h9E37_79B9 * 32'(s + i + 1);
    return r;
  endfunction

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(a_idle && b_idle) && n < 40) begin
      tick();
      n++;
    end
    nvec++;
    if (!(a_idle && b_idle)) begin
      nerr++;
      $display("FAIL wait_idle: a_idle=%b b_idle=%b after %0d cycles, required both 1", a_idle, b_idle, n);
    end
  endtask

  task automatic test_reset();
    ap_rst = 1'b1; ap_start = 1'b1; args_in = pat(7); task_mask = 7'h7F;
    task_done = 7'h7F; tmo_cycles = 32'd0;
    tick(); tick();
    nvec++; if (a_idle !== 1'b1)  begin nerr++; $display("FAIL rst_idle: got %b exp 1", a_idle); end
    nvec++; if (a_done !== 1'b0 || a_ready !== 1'b0) begin nerr++; $display("FAIL rst_done: got %b/%b exp 0/0", a_done, a_ready); end
    nvec++; if (a_tstart !== 7'h00) begin nerr++; $display("FAIL rst_tstart: got %h exp 00", a_tstart); end
    nvec++; if (a_dstat !== 7'h00 || a_tmo !== 1'b0) begin nerr++; $display("FAIL rst_status: got %h/%b exp 00/0", a_dstat, a_tmo); end
    nvec++; if (a_iter !== 32'd0) begin nerr++; $display("FAIL rst_iter: got %0d exp 0", a_iter); end
    nvec++; if (a_args !== 288'd0) begin nerr++; $display("FAIL rst_args: got %h exp 0", a_args); end
    nvec++; if (b_idle !== 1'b1) begin nerr++; $display("FAIL rst_b_idle: got %b exp 1", b_idle); end
    ap_rst = 1'b0; ap_start = 1'b0; task_done = 7'h00;
    tick();
    nvec++; if (a_idle !== 1'b1) begin nerr++; $display("FAIL idle_hold: got %b exp 1", a_idle); end
  endtask

  task automatic test_all_tasks();
    logic [287:0] x;
    int first, ndone;
    x = pat(1);
    args_in = x; task_mask = 7'h7F; ap_start = 1'b1;
    tick();
    ap_start = 1'b0; args_in = pat(2);
    nvec++; if (a_tstart !== 7'h7F) begin nerr++; $display("FAIL launch_tstart: got %h exp 7f", a_tstart); end
    nvec++; if (a_idle !== 1'b0 || a_done !== 1'b0) begin nerr++; $display("FAIL launch_state: idle=%b done=%b exp 0/0", a_idle, a_done); end
    first = 0; ndone = 0;
    for (int k = 1; k <= 30; k++) begin
      task_done = 7'h00;
      for (int i = 0; i < 7; i++) if (sched[i] == k) task_done[i] = 1'b1;
      tick();
      if (k == 1) begin
        nvec++; if (a_tstart !== 7'h00) begin nerr++; $display("FAIL tstart_pulse: got %h exp 00", a_tstart); end
      end
      if (k == 10) begin
        nvec++; if (a_dstat !== 7'h07) begin nerr++; $display("FAIL sticky_mid: got %h exp 07", a_dstat); end
      end
      if (a_done) begin
        ndone++;
        if (first == 0) first = k + 1;
      end
    end
    task_done = 7'h00;
    exp_iter++;
    nvec++; if (first !== 21) begin nerr++; $display("FAIL all_done_cycle: got %0d exp 21", first); end
    nvec++; if (ndone !== 1) begin nerr++; $display("FAIL done_pulses: got %0d exp 1", ndone); end
    nvec++; if (a_iter !== 32'(exp_iter)) begin nerr++; $display("FAIL iter1: got %0d exp %0d", a_iter, exp_iter); end
    nvec++; if (a_args !== x) begin nerr++; $display("FAIL args_latch: got %h exp %h", a_args, x); end
    nvec++; if (a_dstat !== 7'h7F) begin nerr++; $display("FAIL dstat_full: got %h exp 7f", a_dstat); end
    wait_idle();
  endtask

  task automatic test_partial_mask();
    int first;
    task_mask = 7'b0000101; task_done = 7'h7F; args_in = pat(3); ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
    nvec++; if (a_dstat !== 7'h00) begin nerr++; $display("FAIL launch_edge_nosample: got %h exp 00", a_dstat); end
    first = 0;
    for (int k = 1; k <= 30; k++) begin
      task_done = {1'b1, 3'b000, (k >= 4), 1'b0, (k >= 2)};
      tick();
      if (k == 2) begin
        nvec++; if (a_dstat !== 7'h01) begin nerr++; $display("FAIL mask_filter: got %h exp 01", a_dstat); end
      end
      if (a_done && first == 0) first = k + 1;
    end
    exp_iter++;
    nvec++; if (first !== 5) begin nerr++; $display("FAIL partial_done_cycle: got %0d exp 5", first); end
    nvec++; if (a_dstat !== 7'b0000101) begin nerr++; $display("FAIL partial_dstat: got %h exp 05", a_dstat); end
    nvec++; if (a_iter !== 32'(exp_iter)) begin nerr++; $display("FAIL iter2: got %0d exp %0d", a_iter, exp_iter); end
    task_done = 7'h00;
    wait_idle();
  endtask

  task automatic test_done_delay();
    int fa, fb, nb;
    task_mask = 7'h7F; args_in = pat(4); ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
    fa = 0; fb = 0; nb = 0;
    for (int k = 1; k <= 15; k++) begin
      task_done = (k == 5) ? 7'h7F : 7'h00;
      tick();
      if (k == 6) begin
        nvec++; if (b_idle !== 1'b0 || b_done !== 1'b0) begin nerr++; $display("FAIL in_delay: idle=%b done=%b exp 0/0", b_idle, b_done); end
      end
      if (a_done && fa == 0) fa = k + 1;
      if (b_done) begin
        nb++;
        if (fb == 0) fb = k + 1;
      end
    end
    exp_iter++;
    nvec++; if (fa !== 6) begin nerr++; $display("FAIL nodelay_cycle: got %0d exp 6", fa); end
    nvec++; if (fb !== 9) begin nerr++; $display("FAIL delay_cycle: got %0d exp 9", fb); end
    nvec++; if (nb !== 1) begin nerr++; $display("FAIL delay_pulses: got %0d exp 1", nb); end
    task_done = 7'h00;
    wait_idle();
  endtask

  task automatic test_timeout();
    int fa, fb;
    tmo_cycles = 32'd10; task_mask = 7'h7F; args_in = pat(5); ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
    fa = 0; fb = 0;
    for (int k = 1; k <= 20; k++) begin
      task_done = 7'h77;
      tick();
      if (k == 5) begin
        nvec++; if (a_tmo !== 1'b0) begin nerr++; $display("FAIL tmo_early: got %b exp 0", a_tmo); end
      end
      if (a_done && fa == 0) fa = k + 1;
      if (b_done && fb == 0) fb = k + 1;
    end
    exp_iter++;
    nvec++; if (fa !== 11) begin nerr++; $display("FAIL tmo_cycle_a: got %0d exp 11", fa); end
    nvec++; if (fb !== 11) begin nerr++; $display("FAIL tmo_bypass_delay: got %0d exp 11", fb); end
    nvec++; if (a_tmo !== 1'b1 || b_tmo !== 1'b1) begin nerr++; $display("FAIL tmo_flag: got %b/%b exp 1/1", a_tmo, b_tmo); end
    nvec++; if (a_dstat !== 7'h77) begin nerr++; $display("FAIL tmo_dstat: got %h exp 77", a_dstat); end
    // relaunch with done landing exactly on the timeout cycle
    tmo_cycles = 32'd3; task_done = 7'h00; ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
    nvec++; if (a_tmo !== 1'b0 || a_dstat !== 7'h00) begin nerr++; $display("FAIL tmo_clear: got %b/%h exp 0/00", a_tmo, a_dstat); end
    fa = 0;
    for (int k = 1; k <= 8; k++) begin
      task_done = (k == 3) ? 7'h7F : 7'h00;
      tick();
      if (a_done && fa == 0) fa = k + 1;
    end
    exp_iter++;
    nvec++; if (fa !== 4) begin nerr++; $display("FAIL prio_cycle: got %0d exp 4", fa); end
    nvec++; if (a_tmo !== 1'b0) begin nerr++; $display("FAIL done_over_tmo: got %b exp 0", a_tmo); end
    tmo_cycles = 32'd0; task_done = 7'h00;
    wait_idle();
  endtask

  task automatic test_back_to_back();
    task_mask = 7'h00; args_in = pat(10); ap_start = 1'b1;
    tick();
    for (int j = 1; j <= 8; j++) begin
      args_in = pat(10 + j);
      tick();
      if (j % 2 == 1) begin
        nvec++; if (a_done !== 1'b1 || a_ready !== 1'b1) begin nerr++; $display("FAIL b2b_done j=%0d: got %b/%b exp 1/1", j, a_done, a_ready); end
      end else begin
        nvec++; if (a_done !== 1'b0 || a_idle !== 1'b0) begin nerr++; $display("FAIL b2b_run j=%0d: done=%b idle=%b exp 0/0", j, a_done, a_idle); end
        nvec++; if (a_args !== pat(10 + j)) begin nerr++; $display("FAIL b2b_args j=%0d: got %h exp %h", j, a_args, pat(10 + j)); end
        nvec++; if (a_iter !== 32'(exp_iter + j / 2)) begin nerr++; $display("FAIL b2b_iter j=%0d: got %0d exp %0d", j, a_iter, exp_iter + j / 2); end
      end
    end
    ap_start = 1'b0;
    tick(); tick();
    exp_iter += 5;
    nvec++; if (a_iter !== 32'(exp_iter) || a_idle !== 1'b1) begin nerr++; $display("FAIL b2b_end: iter=%0d idle=%b exp %0d/1", a_iter, a_idle, exp_iter); end
    args_in = pat(50);
    tick(); tick();
    nvec++; if (a_args !== pat(18)) begin nerr++; $display("FAIL idle_args_hold: got %h exp %h", a_args, pat(18)); end
    wait_idle();
  endtask

  task automatic test_reset_mid_delay();
    logic seen;
    task_mask = 7'h01; args_in = pat(20); ap_start = 1'b1;
    tick();
    ap_start = 1'b0; task_done = 7'h01;
    tick();
    task_done = 7'h00;
    tick();
    nvec++; if (b_idle !== 1'b0 || b_done !== 1'b0) begin nerr++; $display("FAIL pre_rst_delay: idle=%b done=%b exp 0/0", b_idle, b_done); end
    ap_rst = 1'b1; ap_start = 1'b1;
    tick();
    nvec++; if (b_idle !== 1'b1 || b_done !== 1'b0 || b_ready !== 1'b0) begin nerr++; $display("FAIL mid_rst_state: idle=%b done=%b ready=%b exp 1/0/0", b_idle, b_done, b_ready); end
    nvec++; if (b_dstat !== 7'h00 || b_tmo !== 1'b0 || b_tstart !== 7'h00) begin nerr++; $display("FAIL mid_rst_flags: dstat=%h tmo=%b tstart=%h exp 00/0/00", b_dstat, b_tmo, b_tstart); end
    nvec++; if (b_iter !== 32'd0 || a_iter !== 32'd0) begin nerr++; $display("FAIL mid_rst_iter: got %0d/%0d exp 0/0", b_iter, a_iter); end
    nvec++; if (b_args !== 288'd0) begin nerr++; $display("FAIL mid_rst_args: got %h exp 0", b_args); end
    ap_rst = 1'b0; ap_start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (b_done || !b_idle) seen = 1'b1;
    end
    nvec++; if (seen !== 1'b0) begin nerr++; $display("FAIL post_rst_quiet: got %b exp 0", seen); end
  endtask

  initial begin
    ap_rst = 1'b1; ap_start = 1'b0; args_in = '0; task_mask = '0;
    task_done = '0; tmo_cycles = '0;
    test_reset();
    test_all_tasks();
    test_partial_mask();
    test_done_delay();
    test_timeout();
    test_back_to_back();
    test_reset_mid_delay();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/tapa_global_fsm_gen2.md
TAPA_GLOBAL_FSM_GEN2 -- requirements
Module: tapa_global_fsm_gen2

Interface
REQ-001 SHALL have parameter NUM_TASKS, default 7: number of child tasks supervised (1..64).
REQ-002 SHALL have parameter ARG_W, default 288: total packed scalar-argument width.
REQ-003 SHALL have parameter DONE_DELAY, default 0: extra cycles between all-done and ap_done (0..255).
REQ-004 SHALL have parameter TMO_W, default 32: timeout counter width.
REQ-005 SHALL have one clock and a synchronous, active-high reset, with the following ports:
- ap_clk  in  1  clock; all state on rising edge.
- ap_rst  in  1  synchronous active-high reset.
- ap_start  in  1  launch request.
- ap_done  out  1  one-cycle completion pulse.
- ap_ready  out  1  equals ap_done.
- ap_idle  out  1  high in IDLE.
- args_in  in  ARG_W  packed scalar arguments.
- args_out  out  ARG_W  arguments latched at launch.
- task_mask  in  NUM_TASKS  participating tasks, sampled at launch.
- task_start  out  NUM_TASKS  one-cycle start pulse per participating task.
- task_done  in  NUM_TASKS  per-task done, pulse or level.
- done_status  out  NUM_TASKS  sticky per-task done vector.
- tmo_cycles  in  TMO_W  RUN timeout; 0 disables it.
- tmo_err  out  1  sticky timeout flag.
- iter_count  out  32  completed launches, wraps.

Function
REQ-006 SHALL implement states IDLE, RUN, DELAY, DONE.
REQ-007 In IDLE or DONE with ap_start=1, the block SHALL perform a launch on that clock edge:
- args_out<=args_in; mask_q<=task_mask; done_status<=0; tmo_err<=0; timer<=0.
- task_start<=task_mask for exactly the next cycle.
- state<=RUN.
REQ-008 In IDLE with ap_start=0, the block SHALL hold state; args_out SHALL retain its last value.
REQ-009 In RUN, each cycle the block SHALL compute done_status<=done_status | (task_done & mask_q); task_done bits outside mask_q SHALL be ignored.
REQ-010 task_done SHALL NOT be sampled in IDLE, DELAY, or DONE, nor on the launch edge itself.
REQ-011 In RUN, the all-done condition SHALL be ((done_status|task_done)&mask_q)==mask_q; this includes same-cycle completion, and mask_q==0 gives all-done on the first RUN cycle.
REQ-012 On all-done in RUN, the next state SHALL be DONE if DONE_DELAY==0; otherwise the block SHALL load cnt<=DONE_DELAY-1 and go to DELAY.
REQ-013 In DELAY, the block SHALL go to DONE when cnt==0, else decrement cnt; DELAY SHALL therefore last exactly DONE_DELAY cycles.
REQ-014 In RUN, timer SHALL increment each cycle.
REQ-015 If tmo_cycles!=0, all-done is false, and timer==tmo_cycles-1, the block SHALL set tmo_err<=1 and go directly to DONE, bypassing DELAY.
REQ-016 All-done SHALL take priority over timeout in the same cycle.
REQ-017 DONE SHALL last exactly one cycle:
- ap_done=ap_ready=1.
- iter_count<=iter_count+1, wrapping modulo 2^32.
- Next state SHALL be RUN if ap_start=1 (back-to-back launch per REQ-007), else IDLE.
REQ-018 ap_idle, ap_done, and ap_ready SHALL be decoded combinationally from state.
REQ-019 Total latency SHALL be: launch edge, then >=1 RUN cycle, then DONE_DELAY cycles, then 1 DONE cycle.
REQ-020 done_status and tmo_err SHALL remain stable from DONE until the next launch.

Reset
REQ-021 With ap_rst=1 at a clock edge, from any state including mid-RUN or DELAY, the block SHALL apply:
- state<=IDLE; task_start=0; done_status=0; tmo_err=0; iter_count=0; args_out=0; timer=0; cnt=0.
- ap_done=ap_ready=0; ap_idle=1 from the cycle after reset.
REQ-022 ap_start SHALL be ignored while ap_rst=1.

Verification
REQ-023 NUM_TASKS=7, DONE_DELAY=0, mask=7'h7F, args_in=X, start pulse; done bits pulsed on staggered cycles 3..20 -> task_start=7'h7F for 1 cycle, args_out=X, ap_done 1 cycle after last done, iter_count=1.
REQ-024 mask=7'b0000101, tasks 0 and 2 done as levels, task 1 never done -> completes; done_status=7'b0000101.
REQ-025 DONE_DELAY=3, all done at RUN cycle 5 -> DELAY 3 cycles, ap_done at cycle 9 after launch.
REQ-026 tmo_cycles=10, task 3 never done -> tmo_err=1 and ap_done on RUN cycle 10; done_status bit3=0; next launch clears tmo_err.
REQ-027 ap_start held high, mask=0 -> continuous RUN,DONE alternation; iter_count increments every 2 cycles; args re-latched each launch.
REQ-028 ap_rst asserted mid-DELAY -> IDLE next cycle, ap_done never pulses, all outputs at reset values.
